fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, drives a req/ack instruction-memory port and holds the IF/ID pipeline register. It sits directly upstream of the hazard detection unit. It consumes that unit's `PCWrite` and `IF_ID_Write` stall controls and the ID-stage branch redirect, and it produces the `IF_ID_*` fields decoded in ID.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack instruction-memory port and IF/ID register.
// Redirects win over stalls; a redirect with a request in flight drains it in DROP.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_hold_pc4;
  logic [31:0] r_hold_instr;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  logic        w_stall;
  logic [31:0] w_fa_plus4;

  assign w_stall    = !PCWrite || !IF_ID_Write;
  assign w_fa_plus4 = r_fetch_addr + 32'd4;

  assign imem_req    = r_req;
  assign imem_addr   = r_fetch_addr;
  assign IF_ID_PC4   = r_ifid_pc4;
  assign IF_ID_Instr = r_ifid_instr;
  assign IF_ID_Valid = r_ifid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_hold_pc4   <= '0;
      r_hold_instr <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
          if (PCSrc) begin
            r_pc         <= BranchTarget;
            r_fetch_addr <= BranchTarget;
          end
        end
        REQ: begin
          if (PCSrc) begin
            r_pc <= BranchTarget;
            // Without an ack the old request must finish before the address may change.
            if (imem_ack) r_fetch_addr <= BranchTarget;
            else          r_state      <= DROP;
          end else if (imem_ack) begin
            if (!w_stall) begin
              r_ifid_pc4   <= w_fa_plus4;
              r_ifid_instr <= imem_rdata;
              r_ifid_valid <= 1'b1;
              r_pc         <= w_fa_plus4;
              r_fetch_addr <= w_fa_plus4;
            end else begin
              r_hold_pc4   <= w_fa_plus4;
              r_hold_instr <= imem_rdata;
              r_state      <= HOLD;
              r_req        <= 1'b0;
            end
          end else if (IF_ID_Write) begin
            r_ifid_pc4   <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (PCSrc) begin
            r_pc         <= BranchTarget;
            r_fetch_addr <= BranchTarget;
            r_state      <= REQ;
            r_req        <= 1'b1;
          end else if (!w_stall) begin
            r_ifid_pc4   <= r_hold_pc4;
            r_ifid_instr <= r_hold_instr;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_hold_pc4;
            r_fetch_addr <= r_hold_pc4;
            r_state      <= REQ;
            r_req        <= 1'b1;
          end
        end
        DROP: begin
          if (PCSrc) r_pc <= BranchTarget;
          if (imem_ack) begin
            r_fetch_addr <= PCSrc ? BranchTarget : r_pc;
            r_state      <= REQ;
          end
          if (IF_ID_Write) begin
            r_ifid_pc4   <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase

      if (IF_Flush) begin
        r_ifid_pc4   <= '0;
        r_ifid_instr <= '0;
        r_ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a wait-programmable memory responder
// returning addr<<2, plus a second instance exercising PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b1;
  logic        IF_ID_Write = 1'b1;
  logic        IF_Flush = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = '0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;

  logic        w2_req;
  logic [31:0] w2_addr;
  logic [31:0] w2_pc4;
  logic [31:0] w2_instr;
  logic        w2_valid;

  int unsigned wait_n = 0;
  int unsigned cnt;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_Flush(IF_Flush), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Valid(IF_ID_Valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_Flush(IF_Flush), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .imem_req(w2_req), .imem_addr(w2_addr), .imem_ack(w2_req),
    .imem_rdata(w2_addr << 2), .IF_ID_PC4(w2_pc4), .IF_ID_Instr(w2_instr),
    .IF_ID_Valid(w2_valid)
  );

  // Ack arrives after wait_n cycles of a continuously asserted request.
  assign imem_ack   = imem_req && (cnt == wait_n);
  assign imem_rdata = imem_addr << 2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 0;
    else if (imem_req && imem_ack) cnt <= 0;
    else if (imem_req)             cnt <= cnt + 1;
    else                           cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid);
    check({tag, "_pc4"}, IF_ID_PC4, pc4);
    check({tag, "_instr"}, IF_ID_Instr, instr);
    check({tag, "_valid"}, {31'b0, IF_ID_Valid}, {31'b0, valid});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    tick();
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_wrap_addr", w2_addr, 32'hFFFF_FFFC);

    // Zero-wait streaming, plus wrap instance
    wait_n = 0;
    do_reset();
    check("s1_req", {31'b0, imem_req}, 32'h1);
    check("s1_addr0", imem_addr, 32'h0);
    check("s1_wrap_addr0", w2_addr, 32'hFFFF_FFFC);
    tick();
    check_ifid("s1_a", 32'h4, 32'h0, 1'b1);
    check("s1_wrap_addr1", w2_addr, 32'h0);
    check("s1_wrap_pc4", w2_pc4, 32'h0);
    check("s1_wrap_instr", w2_instr, 32'hFFFF_FFF0);
    tick();
    check_ifid("s1_b", 32'h8, 32'h10, 1'b1);
    tick();
    check_ifid("s1_c", 32'hC, 32'h20, 1'b1);

    // Two-cycle load-use stall at fetch of 0x8
    do_reset();
    tick();
    tick();
    check("s2_addr8", imem_addr, 32'h8);
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    tick();
    check_ifid("s2_hold1", 32'h8, 32'h10, 1'b1);
    check("s2_req_hold1", {31'b0, imem_req}, 32'h0);
    tick();
    check_ifid("s2_hold2", 32'h8, 32'h10, 1'b1);
    check("s2_req_hold2", {31'b0, imem_req}, 32'h0);
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    tick();
    check_ifid("s2_release", 32'hC, 32'h20, 1'b1);
    check("s2_addrC", imem_addr, 32'hC);
    tick();
    check_ifid("s2_next", 32'h10, 32'h30, 1'b1);

    // Two wait cycles per fetch
    wait_n = 2;
    do_reset();
    tick();
    tick();
    tick();
    check_ifid("s3_first", 32'h4, 32'h0, 1'b1);
    tick();
    check_ifid("s3_bub1", 32'h0, 32'h0, 1'b0);
    check("s3_addr_w1", imem_addr, 32'h4);
    tick();
    check_ifid("s3_bub2", 32'h0, 32'h0, 1'b0);
    check("s3_addr_w2", imem_addr, 32'h4);
    tick();
    check_ifid("s3_second", 32'h8, 32'h10, 1'b1);

    // Redirect with flush while a 3-cycle request to 0x10 is outstanding
    wait_n = 0;
    do_reset();
    repeat (4) tick();
    check("s4_addr10", imem_addr, 32'h10);
    wait_n = 3;
    tick();
    PCSrc = 1'b1; IF_Flush = 1'b1; BranchTarget = 32'h100;
    tick();
    PCSrc = 1'b0; IF_Flush = 1'b0;
    check_ifid("s4_flush", 32'h0, 32'h0, 1'b0);
    check("s4_drop_addr", imem_addr, 32'h10);
    check("s4_drop_req", {31'b0, imem_req}, 32'h1);
    tick();
    check("s4_drop_addr2", imem_addr, 32'h10);
    tick();
    check("s4_target", imem_addr, 32'h100);
    check_ifid("s4_discard", 32'h0, 32'h0, 1'b0);
    wait_n = 0;
    tick();
    check_ifid("s4_tgt_instr", 32'h104, 32'h400, 1'b1);
    check("s4_addr104", imem_addr, 32'h104);

    // Redirect in the same cycle as a stall
    do_reset();
    tick();
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    PCSrc = 1'b1; IF_Flush = 1'b1; BranchTarget = 32'h40;
    tick();
    PCWrite = 1'b1; IF_ID_Write = 1'b1; PCSrc = 1'b0; IF_Flush = 1'b0;
    check_ifid("s5_bubble", 32'h0, 32'h0, 1'b0);
    check("s5_addr40", imem_addr, 32'h40);
    tick();
    check_ifid("s5_tgt", 32'h44, 32'h100, 1'b1);

    // Asynchronous reset in the middle of a wait
    do_reset();
    tick();
    tick();
    wait_n = 3;
    IF_ID_Write = 1'b0;
    tick();
    check("s6_wait_addr", imem_addr, 32'h8);
    check_ifid("s6_pre", 32'h8, 32'h10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_req", {31'b0, imem_req}, 32'h0);
    check("s6_addr", imem_addr, 32'h0);
    check_ifid("s6_rst", 32'h0, 32'h0, 1'b0);
    check("s6_wrap_addr", w2_addr, 32'hFFFF_FFFC);
    IF_ID_Write = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
